mux_arb_n: RTL

- Parametrised M:1, N-bit multiplexer with a registered output stage and valid/ready handshaking on every channel.
- Successor to the combinational 2:1 and 4:1 muxes. Generalises channel count and adds a round-robin arbitration mode alongside manual select.
- Used wherever several producers share one downstream consumer.
- Output is registered, so latency is one cycle and full throughput is sustained.

---
 rtl/mux_arb_n.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: M:1, N-bit multiplexer with a registered output stage and
// valid/ready handshaking on every channel.
//
// Two grant modes:
//   mode=0 : manual select, the channel is given by sel. A sel value that
//            is not a real channel (sel >= M) never grants anything.
//   mode=1 : round-robin. Channels are scanned from ptr upwards, modulo M,
//            and the first one with in_valid high wins. After each accepted
//            word ptr moves to the channel after the winner.
//
// The output register accepts a new word whenever it is empty or is being
// drained in the same cycle, so back-to-back words flow at 1 word/cycle
// with one cycle of latency.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   mode      0 = manual select, 1 = round-robin
//   sel       channel index used in manual mode
//   in_data   flat input bus, channel i at in_data[i*N +: N]
//   in_valid  per-channel valid
//   in_ready  per-channel ready (combinational, one-hot or zero)
//   out_data  registered output data
//   out_ch    index of the channel that produced out_data
//   out_valid registered output valid
//   out_ready downstream ready
module mux_arb_n #(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [M*N-1:0]  in_data,
    input  logic [M-1:0]    in_valid,
    output logic [M-1:0]    in_ready,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [N-1:0]   chan_data [M];
    logic [SW-1:0]  ptr_reg;
    logic [SW-1:0]  ptr_next;
    logic [SW-1:0]  rr_grant;
    logic           rr_found;
    logic [2*M-1:0] rr_rot;
    logic [SW-1:0]  grant;
    logic           gnt_v;
    logic           can_load;
    logic           fire;
    logic [N-1:0]   grant_data;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*N +: N];
            assign in_ready[gi]  = fire && (grant == SW'(gi));
        end
    endgenerate

    // Rotate the valid vector so that bit 0 corresponds to channel ptr; the
    // first set bit at offset k then maps back to channel (ptr + k) mod M.
    always_comb begin
        int s;
        rr_rot   = {in_valid, in_valid} >> ptr_reg;
        rr_found = 1'b0;
        rr_grant = '0;
        s        = 0;
        for (int k = 0; k < M; k++) begin
            if (!rr_found && rr_rot[k]) begin
                s = 32'(ptr_reg) + k;
                if (s >= M) begin
                    s = s - M;
                end
                rr_found = 1'b1;
                rr_grant = SW'(s);
            end
        end
    end

    always_comb begin
        grant = '0;
        gnt_v = 1'b0;
        if (mode) begin
            grant = rr_grant;
            gnt_v = rr_found;
        end else begin
            grant = sel;
            // Out-of-range select must never produce a grant.
            if (32'(sel) < M) begin
                gnt_v = in_valid[sel];
            end
        end
    end

    assign can_load = !out_valid || out_ready;
    assign fire     = gnt_v && can_load;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < M; i++) begin
            if (grant == SW'(i)) begin
                grant_data = chan_data[i];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (fire && mode) begin
            if (grant == SW'(M-1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_reg   <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (fire) begin
                out_data  <= grant_data;
                out_ch    <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
